// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - direct-mapped cache line refill controller
// Optional critical-word-first fill order: define REFILL_CWF_EN.
module cache_refill_ctrl #(
    parameter int WORDS_LOG2 = 3,
    parameter int IDX_W      = 5,
    parameter int MEM_LAT    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss,
    input  logic [31:0]                    miss_addr,
    output logic                           stall,
    input  logic [3:0]                     cnt_i,
    output logic                           cnt_clr,
    output logic                           mem_rd,
    output logic [31:0]                    mem_addr,
    input  logic [31:0]                    mem_rdata,
    output logic                           line_we,
    output logic [IDX_W-1:0]               line_idx,
    output logic [WORDS_LOG2-1:0]          line_word,
    output logic [31:0]                    line_wdata,
    output logic                           tag_we,
    output logic [32-IDX_W-WORDS_LOG2-3:0] tag_wdata,
    output logic                           fill_done
);

    localparam int TAG_W  = 32 - IDX_W - WORDS_LOG2 - 2;
    localparam int WCNT_W = WORDS_LOG2 + 1;
    localparam logic [3:0]        CAP_CNT   = 4'(MEM_LAT - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'((1 << WORDS_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_TAG
    } state_t;

    state_t                  state_q, state_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORDS_LOG2-1:0]   ptr_q, ptr_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic                    capture;

    // Byte-offset bits never matter for a line fill; the word offset only does with CWF.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{miss_addr[WORDS_LOG2+1:0]};

    assign capture = (state_q == S_WAIT) && (cnt_i == CAP_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        wcnt_d     = wcnt_q;
        stall      = 1'b0;
        cnt_clr    = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        line_we    = 1'b0;
        line_idx   = '0;
        line_word  = '0;
        line_wdata = '0;
        tag_we     = 1'b0;
        tag_wdata  = '0;
        fill_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
                stall   = miss;
                if (miss) begin
                    state_d = S_WAIT;
                    tag_d   = miss_addr[31 -: TAG_W];
                    idx_d   = miss_addr[WORDS_LOG2+2 +: IDX_W];
`ifdef REFILL_CWF_EN
                    ptr_d   = miss_addr[2 +: WORDS_LOG2];
`else
                    ptr_d   = '0;
`endif
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {tag_q, idx_q, ptr_q, 2'b00};
                line_idx = idx_q;
                if (capture) begin
                    line_we    = 1'b1;
                    line_word  = ptr_q;
                    line_wdata = mem_rdata;
                    cnt_clr    = 1'b1;
                    ptr_d      = ptr_q + 1'b1;
                    wcnt_d     = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_WORD) begin
                        state_d = S_TAG;
                    end
                end
            end
            S_TAG: begin
                stall     = 1'b1;
                tag_we    = 1'b1;
                tag_wdata = tag_q;
                line_idx  = idx_q;
                fill_done = 1'b1;
                cnt_clr   = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - randomized self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

    localparam int WL = 3;
    localparam int IW = 5;
    localparam int N  = 1 << WL;
    localparam int TW = 32 - IW - WL - 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss;
    logic [31:0] miss_addr;
    logic [31:0] mem_rdata;

    logic [3:0]    cnt        [2];
    logic          stall      [2];
    logic          cnt_clr    [2];
    logic          mem_rd     [2];
    logic [31:0]   mem_addr   [2];
    logic          line_we    [2];
    logic [IW-1:0] line_idx   [2];
    logic [WL-1:0] line_word  [2];
    logic [31:0]   line_wdata [2];
    logic          tag_we     [2];
    logic [TW-1:0] tag_wdata  [2];
    logic          fill_done  [2];

    bit          busy     [2];
    int          t        [2];
    logic [31:0] fa       [2];
    int          done_cyc [2];
    int          cyc;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl #(.WORDS_LOG2(WL), .IDX_W(IW), .MEM_LAT(4)) u_dut0 (
        .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr), .stall(stall[0]),
        .cnt_i(cnt[0]), .cnt_clr(cnt_clr[0]), .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]),
        .mem_rdata(mem_rdata), .line_we(line_we[0]), .line_idx(line_idx[0]),
        .line_word(line_word[0]), .line_wdata(line_wdata[0]), .tag_we(tag_we[0]),
        .tag_wdata(tag_wdata[0]), .fill_done(fill_done[0])
    );

    cache_refill_ctrl #(.WORDS_LOG2(WL), .IDX_W(IW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr), .stall(stall[1]),
        .cnt_i(cnt[1]), .cnt_clr(cnt_clr[1]), .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]),
        .mem_rdata(mem_rdata), .line_we(line_we[1]), .line_idx(line_idx[1]),
        .line_word(line_word[1]), .line_wdata(line_wdata[1]), .tag_we(tag_we[1]),
        .tag_wdata(tag_wdata[1]), .fill_done(fill_done[1])
    );

    // Shared 4-bit cycle counter beside each controller.
    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst || cnt_clr[d]) cnt[d] <= 4'd0;
            else                    cnt[d] <= cnt[d] + 4'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic check_dut(input int d);
        int          lat, k, w, start;
        bit          cap;
        logic [31:0] a, idx, tg, base;
        string       p;
        p     = $sformatf("d%0d_", d);
        lat   = lat_of(d);
        a     = fa[d];
        idx   = (a >> (WL + 2)) & ((32'd1 << IW) - 1);
        tg    = a >> (WL + 2 + IW);
        base  = a & ~((32'(N) << 2) - 1);
`ifdef REFILL_CWF_EN
        start = int'((a >> 2) % N);
`else
        start = 0;
`endif
        if (!busy[d] || !rst) begin
            check_eq({p, "stall"}, 32'(stall[d]), 32'(miss & rst));
            check_eq({p, "cnt_clr"}, 32'(cnt_clr[d]), 32'd1);
            check_eq({p, "mem_rd"}, 32'(mem_rd[d]), 32'd0);
            check_eq({p, "line_we"}, 32'(line_we[d]), 32'd0);
            check_eq({p, "tag_we"}, 32'(tag_we[d]), 32'd0);
            check_eq({p, "fill_done"}, 32'(fill_done[d]), 32'd0);
            if (!rst) begin
                check_eq({p, "rst_mem_addr"}, mem_addr[d], 32'd0);
                check_eq({p, "rst_line_idx"}, 32'(line_idx[d]), 32'd0);
                check_eq({p, "rst_line_word"}, 32'(line_word[d]), 32'd0);
                check_eq({p, "rst_tag_wdata"}, 32'(tag_wdata[d]), 32'd0);
            end
        end else if (t[d] <= N * lat) begin
            k   = (t[d] - 1) / lat;
            w   = (start + k) % N;
            cap = (t[d] % lat) == 0;
            check_eq({p, "stall"}, 32'(stall[d]), 32'd1);
            check_eq({p, "mem_rd"}, 32'(mem_rd[d]), 32'd1);
            check_eq({p, "mem_addr"}, mem_addr[d], base + 32'(w * 4));
            check_eq({p, "line_we"}, 32'(line_we[d]), 32'(cap));
            check_eq({p, "cnt_clr"}, 32'(cnt_clr[d]), 32'(cap));
            check_eq({p, "tag_we"}, 32'(tag_we[d]), 32'd0);
            check_eq({p, "fill_done"}, 32'(fill_done[d]), 32'd0);
            if (cap) begin
                check_eq({p, "line_word"}, 32'(line_word[d]), 32'(w));
                check_eq({p, "line_wdata"}, line_wdata[d], mem_rdata);
                check_eq({p, "line_idx"}, 32'(line_idx[d]), idx);
            end
        end else begin
            check_eq({p, "stall"}, 32'(stall[d]), 32'd1);
            check_eq({p, "mem_rd"}, 32'(mem_rd[d]), 32'd0);
            check_eq({p, "line_we"}, 32'(line_we[d]), 32'd0);
            check_eq({p, "tag_we"}, 32'(tag_we[d]), 32'd1);
            check_eq({p, "fill_done"}, 32'(fill_done[d]), 32'd1);
            check_eq({p, "cnt_clr"}, 32'(cnt_clr[d]), 32'd1);
            check_eq({p, "tag_wdata"}, 32'(tag_wdata[d]), tg);
            check_eq({p, "line_idx"}, 32'(line_idx[d]), idx);
        end
    endtask

    // Compare at the falling edge, then advance the reference at the rising edge.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_dut(d);
            if (fill_done[d] && done_cyc[d] < 0) done_cyc[d] = cyc;
        end
        cyc++;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                busy[d] = 1'b0;
            end else if (!busy[d]) begin
                if (miss) begin
                    busy[d] = 1'b1;
                    t[d]    = 1;
                    fa[d]   = miss_addr;
                end
            end else if (t[d] == N * lat_of(d) + 1) begin
                busy[d] = 1'b0;
            end else begin
                t[d]++;
            end
        end
        #1;
        mem_rdata = $urandom;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst       = 1'b0;
        miss      = 1'b0;
        miss_addr = 32'd0;
        mem_rdata = 32'd0;
        cyc       = 0;
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; t[d] = 0; fa[d] = 32'd0; done_cyc[d] = -1;
        end
        steps(2);
        rst = 1'b1;
        steps(2);

        // Single fill at 0x1234 with latency measured from the miss cycle.
        miss      = 1'b1;
        miss_addr = 32'h0000_1234;
        cyc       = 0;
        done_cyc[0] = -1;
        done_cyc[1] = -1;
        step();
        miss = 1'b0;
        steps(36);
        check_eq("d0_fill_done_cycle", 32'(done_cyc[0]), 32'd33);
        check_eq("d1_fill_done_cycle", 32'(done_cyc[1]), 32'd9);

        // Reset while the default-latency controller is on word 3.
        miss = 1'b1;
        step();
        miss = 1'b0;
        steps(14);
        rst = 1'b0;
        step();
        rst = 1'b1;
        steps(5);

        // Miss held through the fill while the address changes underneath it.
        miss      = 1'b1;
        miss_addr = 32'h0000_1234;
        steps(10);
        miss_addr = 32'hABCD_5678;
        steps(40);
        miss = 1'b0;
        steps(3);

        for (int i = 0; i < 3000; i++) begin
            miss      = ($urandom_range(0, 3) == 0);
            miss_addr = $urandom;
            rst       = ($urandom_range(0, 199) != 0);
            if (!rst) miss = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
